// File: rtl/wb_scheduler.sv
// Writeback scheduler: arbitrates ALU and load (MAU) results onto a single
// registered register-file write port. It keeps a pending-load scoreboard
// for WAW ordering and decode hazards, and bounds ALU starvation.
module wb_scheduler #(
  parameter int STARVE_LIMIT = 4,  // 1..15
  parameter int MAX_LOADS    = 4   // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mau_valid,
  input  logic [4:0]  mau_rd,
  input  logic [31:0] mau_data,
  output logic        mau_ready,
  input  logic        load_issue,
  input  logic [4:0]  load_rd,
  output logic        load_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  // Bit 0 is held at zero so any 5-bit rd can index directly; x0 is never pending.
  logic [31:0] pending, pending_nxt;
  logic [3:0]  load_cnt, starve_cnt;
  logic        alu_elig, mau_elig, alu_gnt, mau_gnt, any_gnt;
  logic        load_acc, starve_hit, rs1_busy, rs2_busy;
  wb_req_t     win_req;

  // Arbitration: MAU normally wins; a starved ALU gets exactly one grant.
  always_comb begin
    alu_elig   = alu_valid & ~pending[alu_rd];
    mau_elig   = mau_valid;
    starve_hit = (starve_cnt == 4'(STARVE_LIMIT));
    alu_gnt    = ~reset & alu_elig & (~mau_elig | starve_hit);
    mau_gnt    = ~reset & mau_elig & ~alu_gnt;
    any_gnt    = alu_gnt | mau_gnt;
    load_acc   = load_issue & load_ready;
    win_req    = alu_gnt ? '{rd: alu_rd, data: alu_data}
                         : '{rd: mau_rd, data: mau_data};
  end

  assign alu_ready  = alu_gnt;
  assign mau_ready  = mau_gnt;
  assign load_ready = ~reset & (load_cnt < 4'(MAX_LOADS));

  // Decode stalls on a pending load or on the write still sitting in the port.
  assign rs1_busy = (rs1 != 5'd0) & (pending[rs1] | (wr_en & (wr_addr == rs1)));
  assign rs2_busy = (rs2 != 5'd0) & (pending[rs2] | (wr_en & (wr_addr == rs2)));
  assign hazard   = ~reset & (rs1_busy | rs2_busy);

  // Scoreboard next state: clear on load return first so a same-cycle reissue wins.
  always_comb begin
    pending_nxt = pending;
    if (mau_gnt)  pending_nxt[mau_rd]  = 1'b0;
    if (load_acc) pending_nxt[load_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  // Outstanding-load counter; a return with nothing outstanding saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt <= '0;
    end else begin
      case ({load_acc, mau_gnt})
        2'b10:   load_cnt <= load_cnt + 4'd1;
        2'b01:   if (load_cnt != 4'd0) load_cnt <= load_cnt - 4'd1;
        default: load_cnt <= load_cnt;
      endcase
    end
  end

  // Starvation counter: counts consecutive eligible-but-denied ALU cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   starve_cnt <= '0;
    else if (alu_elig & ~alu_gnt) starve_cnt <= starve_hit ? starve_cnt : starve_cnt + 4'd1;
    else                         starve_cnt <= '0;
  end

  // Registered write port; writes to x0 complete the handshake but never assert wr_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= any_gnt & (win_req.rd != 5'd0);
      if (any_gnt) begin
        wr_addr <= win_req.rd;
        wr_data <= win_req.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: a cycle-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_scheduler;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_LOADS    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 0, mau_valid = 0, load_issue = 0;
  logic [4:0]  alu_rd = 0, mau_rd = 0, load_rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] alu_data = 0, mau_data = 0;
  logic        alu_ready, mau_ready, load_ready, hazard, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_chk = 0;
  int n_err = 0;

  wb_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_LOADS(MAX_LOADS)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mau_valid(mau_valid), .mau_rd(mau_rd), .mau_data(mau_data), .mau_ready(mau_ready),
    .load_issue(load_issue), .load_rd(load_rd), .load_ready(load_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model state: which registers await a load, how many loads are
  // outstanding, how long the ALU has waited, and the write due this cycle.
  bit          m_pend[32];
  int          m_count = 0;
  int          m_starve = 0;
  bit          m_wen = 0;
  logic [4:0]  m_waddr = 0;
  logic [31:0] m_wdata = 0;
  bit          e_ae, e_ag, e_mg, e_lr, e_hz;

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && (m_pend[r] || (m_wen && m_waddr == r));
  endfunction

  // Per-cycle compare at the falling edge, then advance the model one cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_mau_ready", mau_ready, 0);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_hazard", hazard, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      foreach (m_pend[i]) m_pend[i] = 0;
      m_count = 0; m_starve = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      e_ae = alu_valid && !m_pend[alu_rd];
      e_ag = e_ae && (!mau_valid || m_starve == STARVE_LIMIT);
      e_mg = mau_valid && !e_ag;
      e_lr = m_count < MAX_LOADS;
      e_hz = busy(rs1) || busy(rs2);
      chk("alu_ready", alu_ready, e_ag);
      chk("mau_ready", mau_ready, e_mg);
      chk("load_ready", load_ready, e_lr);
      chk("hazard", hazard, e_hz);
      chk("wr_en", wr_en, m_wen);
      if (m_wen) begin
        chk("wr_addr", wr_addr, m_waddr);
        chk("wr_data", wr_data, m_wdata);
      end
      m_wen = 0;
      if (e_ag) begin m_wen = alu_rd != 0; m_waddr = alu_rd; m_wdata = alu_data; end
      if (e_mg) begin m_wen = mau_rd != 0; m_waddr = mau_rd; m_wdata = mau_data; end
      m_starve = (e_ae && !e_ag) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
      if (e_mg) m_pend[mau_rd] = 0;
      if (load_issue && e_lr && load_rd != 0) m_pend[load_rd] = 1;
      if (load_issue && e_lr && !e_mg) m_count++;
      else if (e_mg && !(load_issue && e_lr) && m_count > 0) m_count--;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; mau_valid = 0; load_issue = 0; rs1 = 0; rs2 = 0;
  endtask

  logic [9:0] gseq;

  initial begin
    // Reset: requests present but nothing may be granted.
    alu_valid = 1; alu_rd = 3; mau_valid = 1; mau_rd = 2; mau_data = 32'h2;
    load_issue = 1; load_rd = 4; rs1 = 3;
    step(); step(); #1;
    chk("r_alu_ready", alu_ready, 0);
    chk("r_mau_ready", mau_ready, 0);
    chk("r_load_ready", load_ready, 0);
    chk("r_wr_en", wr_en, 0);
    // First cycle after release grants the MAU.
    step();
    alu_valid = 0; load_issue = 0; rs1 = 0; reset = 0; #1;
    chk("first_mau_grant", mau_ready, 1);
    step(); mau_valid = 0; #1;
    chk("first_wr", {wr_en, wr_addr}, {1'b1, 5'd2});

    // Load to r5 stalls decode until the load result has been written.
    step(); load_issue = 1; load_rd = 5; #1;
    chk("a_load_ready", load_ready, 1);
    step(); load_issue = 0; rs1 = 5; #1;
    chk("a_hazard_pend", hazard, 1);
    step(); step(); step();
    mau_valid = 1; mau_rd = 5; mau_data = 32'h1111_1111;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h2222_2222; #1;
    chk("a_alu_blocked", alu_ready, 0);
    chk("a_mau_grant", mau_ready, 1);
    step(); mau_valid = 0; #1;
    chk("a_wr_mau", {wr_en, wr_addr, wr_data}, {1'b1, 5'd5, 32'h1111_1111});
    chk("a_alu_now", alu_ready, 1);
    chk("a_hazard_wr", hazard, 1);
    step(); alu_valid = 0; #1;
    chk("a_wr_alu", wr_data, 32'h2222_2222);
    step(); #1;
    chk("a_hazard_clear", hazard, 0);
    rs1 = 0;

    // Continuous contention: MAU x4 then ALU, repeating.
    alu_valid = 1; alu_rd = 3; alu_data = 32'hAAAA_0003;
    mau_valid = 1; mau_rd = 4; mau_data = 32'h4444_4444;
    for (int i = 0; i < 10; i++) begin
      #1 gseq[i] = alu_ready;
      step();
    end
    chk("b_grant_seq", gseq, 10'b10_0001_0000);
    idle(); step();

    // Load limit and simultaneous issue/return.
    for (int i = 1; i <= 4; i++) begin
      load_issue = 1; load_rd = 5'(i); #1;
      chk("c_load_ready", load_ready, 1);
      step();
    end
    load_issue = 0; #1;
    chk("c_full", load_ready, 0);
    load_issue = 1; load_rd = 6; mau_valid = 1; mau_rd = 1; mau_data = 32'h100; #1;
    chk("c_full_mau", mau_ready, 1);
    step(); load_issue = 0; mau_valid = 0; rs1 = 6; #1;
    chk("c_cnt3", load_ready, 1);
    chk("c_r6_not_pend", hazard, 0);
    load_issue = 1; load_rd = 6; mau_valid = 1; mau_rd = 2; mau_data = 32'h200;
    step(); load_issue = 0; mau_valid = 0; #1;
    chk("c_still3", load_ready, 1);
    chk("c_r6_pend", hazard, 1);
    load_issue = 1; load_rd = 7;
    step(); load_issue = 0; #1;
    chk("c_full_again", load_ready, 0);
    foreach (gseq[i]) if (i < 4) begin
      mau_valid = 1; mau_rd = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : (i == 2) ? 5'd6 : 5'd7;
      mau_data = 32'h3000 + i;
      step();
    end
    mau_valid = 0; #1;
    chk("c_drained", load_ready, 1);
    chk("c_r6_free", hazard, 0);
    rs1 = 0;

    // Same-index set and clear: the new load keeps r9 pending.
    load_issue = 1; load_rd = 9;
    step(); mau_valid = 1; mau_rd = 9; mau_data = 32'h9;
    step(); load_issue = 0; mau_valid = 0; rs2 = 9; #1;
    chk("d_set_wins", hazard, 1);
    step(); #1;
    chk("d_still_pend", hazard, 1);
    mau_valid = 1;
    step(); mau_valid = 0;
    step(); #1;
    chk("d_clear", hazard, 0);
    rs2 = 0;

    // Write to x0 handshakes but never writes; x0 never hazards.
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD_BEEF; #1;
    chk("e_x0_ready", alu_ready, 1);
    step(); alu_valid = 0; rs1 = 0; rs2 = 0; #1;
    chk("e_x0_no_wr", wr_en, 0);
    chk("e_x0_hazard", hazard, 0);

    // Reset mid-flight discards the pending load and the in-flight write.
    load_issue = 1; load_rd = 7;
    step(); load_issue = 0; alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
    step(); alu_valid = 0; rs1 = 7; #1;
    chk("f_wr_before", wr_en, 1);
    chk("f_hz_before", hazard, 1);
    reset = 1; #1;
    chk("f_wr_in_rst", wr_en, 0);
    chk("f_hz_in_rst", hazard, 0);
    step(); step();
    reset = 0; #1;
    chk("f_hz_after", hazard, 0);
    step(); #1;
    chk("f_no_wr_after", wr_en, 0);
    rs1 = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 Parameter STARVE_LIMIT, 4, consecutive ALU denials before ALU is forced to win one grant (range 1..15).
REQ-002 Parameter MAX_LOADS, 4, maximum outstanding loads tracked (range 1..15).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 alu_valid/alu_rd/alu_data  in  1/5/32  ALU writeback request, destination, value.
REQ-006 alu_ready  out  1  ALU request accepted this cycle when alu_valid & alu_ready.
REQ-007 mau_valid/mau_rd/mau_data  in  1/5/32  memory-unit (load) writeback request, destination, value.
REQ-008 mau_ready  out  1  MAU request accepted this cycle when mau_valid & mau_ready.
REQ-009 load_issue/load_rd  in  1/5  a load is issued with destination load_rd.
REQ-010 load_ready  out  1  load issue may be accepted.
REQ-011 rs1/rs2  in  5  source registers of instruction being decoded.
REQ-012 hazard  out  1  decode must stall.
REQ-013 wr_en/wr_addr/wr_data  out  1/5/32  single register-file write port, registered.

Function
REQ-014 Scoreboard pending[31:1]; x0 never pending.
REQ-015 Load accepted = load_issue & load_ready; sets pending[load_rd] at next edge unless load_rd = 0.
REQ-016 MAU accept clears pending[mau_rd] at next edge; simultaneous set and clear of same index -> set wins.
REQ-017 Outstanding-load counter: +1 on load accept, -1 on MAU accept, unchanged when both; load_ready = (count < MAX_LOADS).
REQ-018 ALU eligible = alu_valid & ~pending[alu_rd] (WAW ordering: ALU never overwrites a register awaiting a load).
REQ-019 MAU eligible = mau_valid; at most one grant per cycle.
REQ-020 Only one eligible -> it is granted; both eligible -> MAU granted, except when starve_cnt = STARVE_LIMIT -> ALU granted.
REQ-021 starve_cnt: +1 (saturating at STARVE_LIMIT) when ALU eligible and not granted; cleared when ALU granted or ALU not eligible.
REQ-022 alu_ready/mau_ready are combinational grant signals; neither depends on its own valid beyond REQ-018/019.
REQ-023 Accept in cycle N -> wr_en = 1, wr_addr = rd, wr_data = data during cycle N+1 only; no accept -> wr_en = 0 in N+1.
REQ-024 Accepted write with rd = 0: handshake completes, wr_en stays 0.
REQ-025 hazard = 1 when (rs1 != 0 and (pending[rs1] or (wr_en and wr_addr = rs1))) or same for rs2; combinational.
REQ-026 MAU write to non-pending register: accepted and written, scoreboard unchanged, counter still decrements (saturating at 0).

Reset
REQ-027 On reset: pending = 0, count = 0, starve_cnt = 0, wr_en = 0, wr_addr = 0, wr_data = 0.
REQ-028 During reset: alu_ready = 0, mau_ready = 0, load_ready = 0, hazard = 0; first grant possible in first cycle after deassertion.
REQ-029 Reset mid-operation discards in-flight write and all pending state; no write issued after deassertion for pre-reset requests.

Verification
REQ-030 Load issue rd=5, then rs1=5 -> hazard=1 until MAU write rd=5 accepted; hazard=1 also in the wr_en cycle, 0 the cycle after.
REQ-031 alu_valid rd=5 while pending[5] -> alu_ready=0; after MAU rd=5 accepted -> ALU granted next cycle, wr_addr=5 with ALU data after MAU data.
REQ-032 alu_valid and mau_valid held high continuously, STARVE_LIMIT=4 -> grant sequence MAU x4, ALU, MAU x4, ALU...
REQ-033 Issue 4 loads (MAX_LOADS=4) -> load_ready=0; same cycle load issue plus MAU accept at count=4 not allowed, at count=3 count stays 3.
REQ-034 ALU write rd=0 data=0xDEADBEEF -> alu_ready=1, wr_en=0 next cycle; rs1=0 never raises hazard.
REQ-035 Assert reset while pending[7] set and wr_en=1 -> wr_en=0, hazard=0 immediately; after release rs1=7 -> hazard=0.
